// File: rtl/exec_ctrl_pkg.sv
// Shared encodings for the run/halt/step controller and its dcache port mux.
package exec_ctrl_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      ST_HALTED = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_MEMRD  = 3'd3,
      ST_MEMWR  = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_RUN   = 3'd1,
      OP_HALT  = 3'd2,
      OP_STEP  = 3'd3,
      OP_RD    = 3'd4,
      OP_WR    = 3'd5,
      OP_SETBP = 3'd6,
      OP_CLRBP = 3'd7
   } cmd_op_e;

   typedef enum logic [1:0] {
      DC_IDLE = 2'd0,
      DC_CORE = 2'd1,
      DC_HOST = 2'd2
   } dc_sel_e;

   // Only commands that cannot disturb a running core are legal while running.
   function automatic logic op_ok_in_run(cmd_op_e op);
      return (op == OP_NOP) || (op == OP_HALT);
   endfunction

endpackage

// File: rtl/exec_ctrl_mux.sv
// Combinational dcache port select: the core owns the port while it is
// executing, the host owns it for one cycle of a debug access, otherwise the
// port is held quiet with all fields at zero.
module dcache_port_mux
   import exec_ctrl_pkg::*;
#(
   parameter int DADDR_W = 5
) (
   input  dc_sel_e              sel,
   input  logic                 core_rd,
   input  logic                 core_wr,
   input  logic [DADDR_W-1:0]   core_addr,
   input  logic [XLEN-1:0]      core_wdata,
   input  logic                 host_rd,
   input  logic                 host_wr,
   input  logic [DADDR_W-1:0]   host_addr,
   input  logic [XLEN-1:0]      host_wdata,
   output logic                 dc_readen,
   output logic                 dc_writeen,
   output logic [DADDR_W-1:0]   dc_addr,
   output logic [XLEN-1:0]      dc_wdata
);

   // Route the selected requester to the dcache, zeros when idle.
   always_comb begin
      dc_readen  = 1'b0;
      dc_writeen = 1'b0;
      dc_addr    = '0;
      dc_wdata   = '0;
      unique case (sel)
         DC_CORE: begin
            dc_readen  = core_rd;
            dc_writeen = core_wr;
            dc_addr    = core_addr;
            dc_wdata   = core_wdata;
         end
         DC_HOST: begin
            dc_readen  = host_rd;
            dc_writeen = host_wr;
            dc_addr    = host_addr;
            dc_wdata   = host_wdata;
         end
         default: begin
            dc_readen  = 1'b0;
            dc_writeen = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/exec_ctrl.sv
// Run/halt/single-step controller with PC breakpoint and host dcache access
// for the single-cycle RV32 core.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  HALTED    | core frozen, host commands accepted, dcache port idle
//  RUN       | core executes while no breakpoint hit; only NOP/HALT legal
//  STEP      | core executes exactly one instruction, then HALTED
//  MEMRD     | host read owns the dcache for one cycle, data captured
//  MEMWR     | host write owns the dcache for one cycle
module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int DADDR_W = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [2:0]           cmd_op_i,
   input  logic [31:0]          cmd_addr_i,
   input  logic [31:0]          cmd_data_i,
   output logic                 rsp_valid_o,
   output logic [31:0]          rsp_data_o,
   output logic                 rsp_err_o,
   input  logic [31:0]          pc_i,
   output logic                 pc_en_o,
   input  logic                 core_rd_i,
   input  logic                 core_wr_i,
   input  logic [DADDR_W-1:0]   core_addr_i,
   input  logic [31:0]          core_wdata_i,
   output logic                 dc_readen_o,
   output logic                 dc_writeen_o,
   output logic [DADDR_W-1:0]   dc_addr_o,
   output logic [31:0]          dc_wdata_o,
   input  logic [31:0]          dc_rdata_i,
   output logic                 halted_o,
   output logic [CNT_W-1:0]     cycle_cnt_o,
   output logic [CNT_W-1:0]     retired_o
);

   state_e               state_q;
   logic [31:0]          bp_addr_q;
   logic                 bp_valid_q;
   logic                 bp_skip_q;
   logic [DADDR_W-1:0]   host_addr_q;
   logic [31:0]          host_wdata_q;

   cmd_op_e              op;
   logic                 cmd_acc;
   logic                 in_run;
   logic                 bp_hit;
   dc_sel_e              dc_sel;

   assign op          = cmd_op_e'(cmd_op_i);
   assign cmd_ready_o = (state_q == ST_HALTED) || (state_q == ST_RUN);
   assign cmd_acc     = cmd_valid_i & cmd_ready_o;
   assign in_run      = (state_q == ST_RUN);
   assign halted_o    = (state_q == ST_HALTED);

   // bp_skip lets a RUN issued while parked on the breakpoint PC execute it.
   assign bp_hit  = in_run & bp_valid_q & (pc_i == bp_addr_q) & ~bp_skip_q;
   assign pc_en_o = (in_run & ~bp_hit) | (state_q == ST_STEP);

   // Main control FSM: command decode, breakpoint stop and registered responses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_HALTED;
         bp_addr_q    <= '0;
         bp_valid_q   <= 1'b0;
         bp_skip_q    <= 1'b0;
         host_addr_q  <= '0;
         host_wdata_q <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_data_o   <= '0;
         rsp_err_o    <= 1'b0;
      end else begin
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
         if (in_run) begin
            bp_skip_q <= 1'b0;
         end
         unique case (state_q)
            ST_HALTED: begin
               if (cmd_acc) begin
                  unique case (op)
                     OP_RUN: begin
                        state_q     <= ST_RUN;
                        bp_skip_q   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                     end
                     OP_STEP: begin
                        state_q <= ST_STEP;
                     end
                     OP_RD: begin
                        state_q     <= ST_MEMRD;
                        host_addr_q <= cmd_addr_i[DADDR_W+1:2];
                     end
                     OP_WR: begin
                        state_q      <= ST_MEMWR;
                        host_addr_q  <= cmd_addr_i[DADDR_W+1:2];
                        host_wdata_q <= cmd_data_i;
                     end
                     OP_SETBP: begin
                        bp_addr_q   <= cmd_addr_i;
                        bp_valid_q  <= 1'b1;
                        rsp_valid_o <= 1'b1;
                     end
                     OP_CLRBP: begin
                        bp_valid_q  <= 1'b0;
                        rsp_valid_o <= 1'b1;
                     end
                     default: begin
                        rsp_valid_o <= 1'b1;
                     end
                  endcase
               end
            end
            ST_RUN: begin
               // A HALT coinciding with a breakpoint stop resolves to one
               // clean response; both paths land in HALTED.
               if (cmd_acc) begin
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= ~op_ok_in_run(op);
                  if (op == OP_HALT) begin
                     state_q <= ST_HALTED;
                  end
               end
               if (bp_hit) begin
                  state_q <= ST_HALTED;
               end
            end
            ST_STEP: begin
               state_q     <= ST_HALTED;
               rsp_valid_o <= 1'b1;
            end
            ST_MEMRD: begin
               state_q     <= ST_HALTED;
               rsp_valid_o <= 1'b1;
               rsp_data_o  <= dc_rdata_i;
            end
            ST_MEMWR: begin
               state_q     <= ST_HALTED;
               rsp_valid_o <= 1'b1;
            end
            default: begin
               state_q <= ST_HALTED;
            end
         endcase
      end
   end

   // Free-running cycle counter and retired-instruction counter, both wrapping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycle_cnt_o <= '0;
         retired_o   <= '0;
      end else begin
         cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
         if (pc_en_o) begin
            retired_o <= retired_o + CNT_W'(1);
         end
      end
   end

   // Pick the dcache owner: executing core first, then a host access cycle.
   always_comb begin
      dc_sel = DC_IDLE;
      if (pc_en_o) begin
         dc_sel = DC_CORE;
      end else if ((state_q == ST_MEMRD) || (state_q == ST_MEMWR)) begin
         dc_sel = DC_HOST;
      end
   end

   dcache_port_mux #(
      .DADDR_W (DADDR_W)
   ) u_dc_mux (
      .sel        (dc_sel),
      .core_rd    (core_rd_i & pc_en_o),
      .core_wr    (core_wr_i & pc_en_o),
      .core_addr  (core_addr_i),
      .core_wdata (core_wdata_i),
      .host_rd    (state_q == ST_MEMRD),
      .host_wr    (state_q == ST_MEMWR),
      .host_addr  (host_addr_q),
      .host_wdata (host_wdata_q),
      .dc_readen  (dc_readen_o),
      .dc_writeen (dc_writeen_o),
      .dc_addr    (dc_addr_o),
      .dc_wdata   (dc_wdata_o)
   );

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: a simple core PC model (pc += 4 per enabled cycle), a
// dcache array, and per-scenario expectations derived from instruction counts.
module tb_exec_ctrl;
   import exec_ctrl_pkg::*;

   localparam int CNT_W   = 32;
   localparam int DADDR_W = 5;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 cmd_valid_i;
   logic                 cmd_ready_o;
   logic [2:0]           cmd_op_i;
   logic [31:0]          cmd_addr_i;
   logic [31:0]          cmd_data_i;
   logic                 rsp_valid_o;
   logic [31:0]          rsp_data_o;
   logic                 rsp_err_o;
   logic [31:0]          pc_i;
   logic                 pc_en_o;
   logic                 core_rd_i;
   logic                 core_wr_i;
   logic [DADDR_W-1:0]   core_addr_i;
   logic [31:0]          core_wdata_i;
   logic                 dc_readen_o;
   logic                 dc_writeen_o;
   logic [DADDR_W-1:0]   dc_addr_o;
   logic [31:0]          dc_wdata_o;
   logic [31:0]          dc_rdata_i;
   logic                 halted_o;
   logic [CNT_W-1:0]     cycle_cnt_o;
   logic [CNT_W-1:0]     retired_o;

   exec_ctrl #(.CNT_W(CNT_W), .DADDR_W(DADDR_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .pc_i(pc_i), .pc_en_o(pc_en_o),
      .core_rd_i(core_rd_i), .core_wr_i(core_wr_i), .core_addr_i(core_addr_i),
      .core_wdata_i(core_wdata_i),
      .dc_readen_o(dc_readen_o), .dc_writeen_o(dc_writeen_o), .dc_addr_o(dc_addr_o),
      .dc_wdata_o(dc_wdata_o), .dc_rdata_i(dc_rdata_i),
      .halted_o(halted_o), .cycle_cnt_o(cycle_cnt_o), .retired_o(retired_o)
   );

   always #5 clk_i = ~clk_i;

   logic [31:0] dmem    [0:31];
   logic [31:0] ref_mem [0:31];
   assign dc_rdata_i = dmem[dc_addr_o];

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_cycle;
   logic [31:0] exp_retired;
   int          en_pulses;

   // One clock: settle, sample, pass a rising edge, update core PC and dcache.
   task automatic tick();
      logic                 we;
      logic                 en;
      logic [DADDR_W-1:0]   wa;
      logic [31:0]          wd;
      #1;
      we = dc_writeen_o;
      wa = dc_addr_o;
      wd = dc_wdata_o;
      en = pc_en_o;
      @(negedge clk_i);
      if (we) dmem[wa] = wd;
      if (en) begin
         pc_i = pc_i + 32'd4;
         en_pulses++;
      end
      exp_cycle = exp_cycle + 32'd1;
      #1;
   endtask

   task automatic apply_reset();
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i       = 1'b0;
      pc_i        = '0;
      exp_cycle   = '0;
      exp_retired = '0;
      #1;
   endtask

   // Drive one command, then wait (bounded) for its response; lat = -1 on timeout.
   task automatic do_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         output logic rdy, output int lat, output logic err,
                         output logic [31:0] rdata);
      rdy         = cmd_ready_o;
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_addr_i  = addr;
      cmd_data_i  = data;
      tick();
      cmd_valid_i = 1'b0;
      cmd_op_i    = '0;
      cmd_addr_i  = '0;
      cmd_data_i  = '0;
      lat   = 1;
      err   = 1'b0;
      rdata = '0;
      while (rsp_valid_o !== 1'b1 && lat < 8) begin
         tick();
         lat++;
      end
      if (rsp_valid_o === 1'b1) begin
         err   = rsp_err_o;
         rdata = rsp_data_o;
      end else begin
         lat = -1;
      end
   endtask

   task automatic test_reset();
      vectors++; if (halted_o !== 1'b1) begin miscompares++; $display("FAIL reset_halted got %b want 1", halted_o); end
      vectors++; if (pc_en_o !== 1'b0) begin miscompares++; $display("FAIL reset_pc_en got %b want 0", pc_en_o); end
      vectors++; if (cycle_cnt_o !== 32'd0) begin miscompares++; $display("FAIL reset_cycle got %0d want 0", cycle_cnt_o); end
      vectors++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_rsp_rdy got %b%b want 01", rsp_valid_o, cmd_ready_o); end
      repeat (10) tick();
      vectors++; if (cycle_cnt_o !== exp_cycle) begin miscompares++; $display("FAIL cycle_10 got %0d want %0d", cycle_cnt_o, exp_cycle); end
      vectors++; if (retired_o !== 32'd0) begin miscompares++; $display("FAIL retired_10 got %0d want 0", retired_o); end
   endtask

   task automatic test_mem_basic();
      ref_mem[3] = 32'hDEADBEEF;
      cmd_valid_i = 1'b1; cmd_op_i = OP_WR; cmd_addr_i = 32'h0C; cmd_data_i = 32'hDEADBEEF;
      tick();
      cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0; cmd_data_i = '0;
      #1;
      vectors++; if (dc_writeen_o !== 1'b1 || dc_addr_o !== 5'd3 || dc_wdata_o !== 32'hDEADBEEF)
         begin miscompares++; $display("FAIL memwr_port got we=%b a=%0d d=%h want 1 3 deadbeef", dc_writeen_o, dc_addr_o, dc_wdata_o); end
      vectors++; if (cmd_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL memwr_busy got rdy=%b rsp=%b want 0 0", cmd_ready_o, rsp_valid_o); end
      tick();
      vectors++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) begin miscompares++; $display("FAIL wr_rsp got v=%b e=%b want 1 0", rsp_valid_o, rsp_err_o); end
      cmd_valid_i = 1'b1; cmd_op_i = OP_RD; cmd_addr_i = 32'h0C;
      tick();
      cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0;
      #1;
      vectors++; if (dc_readen_o !== 1'b1 || dc_writeen_o !== 1'b0 || dc_addr_o !== 5'd3)
         begin miscompares++; $display("FAIL memrd_port got re=%b we=%b a=%0d want 1 0 3", dc_readen_o, dc_writeen_o, dc_addr_o); end
      tick();
      vectors++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== ref_mem[3]) begin miscompares++; $display("FAIL rd_rsp got v=%b d=%h want 1 %h", rsp_valid_o, rsp_data_o, ref_mem[3]); end
      tick();
      vectors++; if (rsp_valid_o !== 1'b0 || rsp_data_o !== 32'd0) begin miscompares++; $display("FAIL rd_rsp_end got v=%b d=%h want 0 0", rsp_valid_o, rsp_data_o); end
   endtask

   task automatic test_mem_random();
      logic        rdy, err;
      int          lat;
      logic [31:0] rd, addr, data;
      int          a;
      int          written[$];
      for (int i = 0; i < 6; i++) begin
         a    = $urandom_range(0, 31);
         data = $urandom;
         addr = ($urandom & ~32'h0000_007C) | (32'(a) << 2);
         do_cmd(OP_WR, addr, data, rdy, lat, err, rd);
         ref_mem[a] = data;
         written.push_back(a);
         vectors++; if (rdy !== 1'b1 || lat != 2 || err !== 1'b0) begin miscompares++; $display("FAIL rnd_wr a=%0d got rdy=%b lat=%0d err=%b want 1 2 0", a, rdy, lat, err); end
      end
      for (int i = 0; i < 6; i++) begin
         a    = written[$urandom_range(0, written.size() - 1)];
         addr = ($urandom & ~32'h0000_007C) | (32'(a) << 2);
         do_cmd(OP_RD, addr, $urandom, rdy, lat, err, rd);
         vectors++; if (lat != 2 || rd !== ref_mem[a]) begin miscompares++; $display("FAIL rnd_rd a=%0d got lat=%0d d=%h want 2 %h", a, lat, rd, ref_mem[a]); end
      end
      vectors++; if (retired_o !== 32'd0 || cycle_cnt_o !== exp_cycle) begin miscompares++; $display("FAIL mem_counters got r=%0d c=%0d want 0 %0d", retired_o, cycle_cnt_o, exp_cycle); end
   endtask

   task automatic test_step();
      logic        rdy, err;
      int          lat;
      logic [31:0] rd, p0;
      p0 = pc_i;
      en_pulses = 0;
      for (int i = 0; i < 2; i++) begin
         do_cmd(OP_STEP, 32'd0, 32'd0, rdy, lat, err, rd);
         exp_retired = exp_retired + 32'd1;
         vectors++; if (lat != 2 || err !== 1'b0 || halted_o !== 1'b1) begin miscompares++; $display("FAIL step_%0d got lat=%0d err=%b halted=%b want 2 0 1", i, lat, err, halted_o); end
      end
      repeat (3) tick();
      vectors++; if (en_pulses != 2) begin miscompares++; $display("FAIL step_pulses got %0d want 2", en_pulses); end
      vectors++; if (retired_o !== exp_retired || pc_i !== p0 + 32'd8) begin miscompares++; $display("FAIL step_retired got r=%0d pc=%h want %0d %h", retired_o, pc_i, exp_retired, p0 + 32'd8); end
   endtask

   task automatic test_breakpoint();
      logic        rdy, err;
      int          lat, n;
      logic [31:0] rd;
      do_cmd(OP_SETBP, 32'h10, 32'd0, rdy, lat, err, rd);
      vectors++; if (lat != 1 || err !== 1'b0) begin miscompares++; $display("FAIL setbp_rsp got lat=%0d err=%b want 1 0", lat, err); end
      do_cmd(OP_RUN, 32'd0, 32'd0, rdy, lat, err, rd);
      vectors++; if (lat != 1 || err !== 1'b0 || halted_o !== 1'b0) begin miscompares++; $display("FAIL run_rsp got lat=%0d err=%b halted=%b want 1 0 0", lat, err, halted_o); end
      n = 0;
      while (halted_o !== 1'b1 && n < 100) begin tick(); n++; end
      exp_retired = exp_retired + 32'd4;
      vectors++; if (halted_o !== 1'b1 || pc_i !== 32'h10) begin miscompares++; $display("FAIL bp_stop got halted=%b pc=%h want 1 00000010", halted_o, pc_i); end
      vectors++; if (retired_o !== exp_retired) begin miscompares++; $display("FAIL bp_retired got %0d want %0d", retired_o, exp_retired); end
      do_cmd(OP_RUN, 32'd0, 32'd0, rdy, lat, err, rd);
      repeat (3) tick();
      vectors++; if (halted_o !== 1'b0 || pc_i !== 32'h1C) begin miscompares++; $display("FAIL bp_resume got halted=%b pc=%h want 0 0000001c", halted_o, pc_i); end
      do_cmd(OP_HALT, 32'd0, 32'd0, rdy, lat, err, rd);
      exp_retired = exp_retired + 32'd4;
      vectors++; if (lat != 1 || pc_en_o !== 1'b0 || halted_o !== 1'b1 || pc_i !== 32'h20) begin miscompares++; $display("FAIL halt_cmd got lat=%0d en=%b halted=%b pc=%h want 1 0 1 00000020", lat, pc_en_o, halted_o, pc_i); end
      vectors++; if (retired_o !== exp_retired || cycle_cnt_o !== exp_cycle) begin miscompares++; $display("FAIL halt_counters got r=%0d c=%0d want %0d %0d", retired_o, cycle_cnt_o, exp_retired, exp_cycle); end
   endtask

   task automatic test_halt_on_bp();
      logic        rdy, err;
      int          lat, n, k;
      logic [31:0] rd, bp;
      k  = $urandom_range(3, 8);
      bp = pc_i + 32'(4 * k);
      do_cmd(OP_SETBP, bp, 32'd0, rdy, lat, err, rd);
      do_cmd(OP_RUN, 32'd0, 32'd0, rdy, lat, err, rd);
      n = 0;
      while (pc_i !== bp && n < 100) begin tick(); n++; end
      vectors++; if (pc_en_o !== 1'b0 || halted_o !== 1'b0) begin miscompares++; $display("FAIL hit_cycle got en=%b halted=%b want 0 0", pc_en_o, halted_o); end
      do_cmd(OP_HALT, 32'd0, 32'd0, rdy, lat, err, rd);
      vectors++; if (lat != 1 || err !== 1'b0 || halted_o !== 1'b1) begin miscompares++; $display("FAIL halt_on_hit got lat=%0d err=%b halted=%b want 1 0 1", lat, err, halted_o); end
      tick();
      exp_retired = exp_retired + 32'(k);
      vectors++; if (rsp_valid_o !== 1'b0 || pc_i !== bp) begin miscompares++; $display("FAIL halt_on_hit_single got rsp=%b pc=%h want 0 %h", rsp_valid_o, pc_i, bp); end
      vectors++; if (retired_o !== exp_retired) begin miscompares++; $display("FAIL halt_on_hit_retired got %0d want %0d", retired_o, exp_retired); end
   endtask

   task automatic test_run_errors();
      logic        rdy, err;
      int          lat;
      logic [31:0] rd, p0, addr;
      logic [2:0]  bad_ops [6];
      bad_ops = '{OP_RUN, OP_STEP, OP_RD, OP_WR, OP_SETBP, OP_CLRBP};
      do_cmd(OP_CLRBP, 32'd0, 32'd0, rdy, lat, err, rd);
      p0 = pc_i;
      do_cmd(OP_RUN, 32'd0, 32'd0, rdy, lat, err, rd);
      core_rd_i   = 1'b1;
      core_addr_i = DADDR_W'($urandom_range(1, 31));
      #1;
      vectors++; if (dc_readen_o !== 1'b1 || dc_addr_o !== core_addr_i) begin miscompares++; $display("FAIL core_pass got re=%b a=%0d want 1 %0d", dc_readen_o, dc_addr_o, core_addr_i); end
      core_rd_i   = 1'b0;
      core_addr_i = '0;
      for (int i = 0; i < 6; i++) begin
         addr = (bad_ops[i] == OP_SETBP) ? pc_i + 32'd8 : $urandom;
         do_cmd(bad_ops[i], addr, $urandom, rdy, lat, err, rd);
         vectors++; if (lat != 1 || err !== 1'b1 || halted_o !== 1'b0 || dc_readen_o !== 1'b0 || dc_writeen_o !== 1'b0)
            begin miscompares++; $display("FAIL run_illegal op=%0d got lat=%0d err=%b halted=%b re=%b we=%b want 1 1 0 0 0", bad_ops[i], lat, err, halted_o, dc_readen_o, dc_writeen_o); end
      end
      do_cmd(OP_NOP, 32'd0, 32'd0, rdy, lat, err, rd);
      vectors++; if (lat != 1 || err !== 1'b0 || halted_o !== 1'b0) begin miscompares++; $display("FAIL run_nop got lat=%0d err=%b halted=%b want 1 0 0", lat, err, halted_o); end
      repeat (4) tick();
      vectors++; if (halted_o !== 1'b0) begin miscompares++; $display("FAIL run_no_bp got halted=%b want 0", halted_o); end
      do_cmd(OP_HALT, 32'd0, 32'd0, rdy, lat, err, rd);
      exp_retired = exp_retired + ((pc_i - p0) >> 2);
      vectors++; if (lat != 1 || err !== 1'b0 || pc_en_o !== 1'b0 || halted_o !== 1'b1) begin miscompares++; $display("FAIL run_halt got lat=%0d err=%b en=%b halted=%b want 1 0 0 1", lat, err, pc_en_o, halted_o); end
      vectors++; if (retired_o !== exp_retired) begin miscompares++; $display("FAIL run_retired got %0d want %0d", retired_o, exp_retired); end
   endtask

   task automatic test_halted_store();
      core_wr_i    = 1'b1;
      core_rd_i    = 1'b1;
      core_addr_i  = DADDR_W'($urandom_range(1, 31));
      core_wdata_i = $urandom | 32'h1;
      tick();
      vectors++; if (dc_writeen_o !== 1'b0 || dc_readen_o !== 1'b0 || dc_addr_o !== '0 || dc_wdata_o !== 32'd0)
         begin miscompares++; $display("FAIL halted_store got we=%b re=%b a=%0d d=%h want 0 0 0 0", dc_writeen_o, dc_readen_o, dc_addr_o, dc_wdata_o); end
      vectors++; if (retired_o !== exp_retired || cycle_cnt_o !== exp_cycle) begin miscompares++; $display("FAIL halted_counters got r=%0d c=%0d want %0d %0d", retired_o, cycle_cnt_o, exp_retired, exp_cycle); end
      core_wr_i = 1'b0; core_rd_i = 1'b0; core_addr_i = '0; core_wdata_i = '0;
   endtask

   task automatic test_reset_mid_write();
      logic saw_rsp;
      cmd_valid_i = 1'b1; cmd_op_i = OP_WR; cmd_addr_i = 32'h14; cmd_data_i = $urandom;
      tick();
      cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0; cmd_data_i = '0;
      #1;
      vectors++; if (dc_writeen_o !== 1'b1 || cmd_ready_o !== 1'b0) begin miscompares++; $display("FAIL pre_abort got we=%b rdy=%b want 1 0", dc_writeen_o, cmd_ready_o); end
      rst_i = 1'b1;
      #1;
      vectors++; if (rsp_valid_o !== 1'b0 || halted_o !== 1'b1 || dc_writeen_o !== 1'b0 || cycle_cnt_o !== 32'd0)
         begin miscompares++; $display("FAIL abort got rsp=%b halted=%b we=%b c=%0d want 0 1 0 0", rsp_valid_o, halted_o, dc_writeen_o, cycle_cnt_o); end
      @(negedge clk_i);
      rst_i = 1'b0; pc_i = '0; exp_cycle = '0; exp_retired = '0;
      saw_rsp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rsp_valid_o !== 1'b0) saw_rsp = 1'b1;
      end
      vectors++; if (saw_rsp !== 1'b0 || halted_o !== 1'b1) begin miscompares++; $display("FAIL post_abort got rsp_seen=%b halted=%b want 0 1", saw_rsp, halted_o); end
      vectors++; if (cycle_cnt_o !== exp_cycle || retired_o !== exp_retired) begin miscompares++; $display("FAIL post_abort_cnt got c=%0d r=%0d want %0d %0d", cycle_cnt_o, retired_o, exp_cycle, exp_retired); end
   endtask

   initial begin
      cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0; cmd_data_i = '0;
      core_rd_i = 1'b0; core_wr_i = 1'b0; core_addr_i = '0; core_wdata_i = '0;
      pc_i = '0; exp_cycle = '0; exp_retired = '0; en_pulses = 0;
      apply_reset();
      test_reset();
      test_mem_basic();
      test_mem_random();
      test_step();
      apply_reset();
      test_breakpoint();
      test_halt_on_bp();
      test_run_errors();
      test_halted_store();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
